uut_perf_monitor: RTL and testbench
===================================

// Module: uut_perf_monitor
// PURPOSE
//  Sits beside fsm_autotest, downstream of the UUT handshake. Times one UUT run (uut_start edge -> uut_finish)
//  in clk cycles, with timeout. Latches the run configuration and status. Serialises a 12-byte result record
//  byte-by-byte for the autotest FSM to write to SD through sdspihost (spi_data_in / spi_w_byte).
// PARAMETERS
//  N_BLOCK_SIZE     32        width of uut_n_blocks (<=32)
//  SCLK_SPEED_SIZE  4         width of uut_sclk_speed
//  CMD18_SIZE       1         width of uut_cmd18 (SCLK_SPEED_SIZE+CMD18_SIZE <= 8)
//  TIMEOUT_CYCLES   32'hFFFF_FFFE  run aborted when cycle count reaches this value
// PORTS
//  clk             in   1    system clock
//  rst             in   1    synchronous, active-high reset
//  uut_start       in   1    level from fsm_autotest; rising edge arms a measurement
//  uut_finish      in   1    UUT completion level
//  uut_n_blocks    in   N_BLOCK_SIZE     run config, latched on start edge
//  uut_sclk_speed  in   SCLK_SPEED_SIZE  run config, latched on start edge
//  uut_cmd18       in   CMD18_SIZE       run config, latched on start edge
//  busy            out  1    1 while in RUN
//  result_valid    out  1    1 while a record is available (DONE)
//  rd_byte         out  8    current record byte (valid while result_valid)
//  rd_last         out  1    rd_byte is record byte 11
//  rd_next         in   1    one-cycle pulse: consume rd_byte, advance index
// BEHAVIOUR
//  Reset: state=IDLE, busy=0, result_valid=0, rd_byte=8'h00, rd_last=0, cycles=0, index=0, overrun=0.
//  Start edge = uut_start & ~start_q (start_q is a registered copy, reset 0).
//  FSM:
//   IDLE -> RUN on start edge: latch config, cycles<=0, overrun<=0.
//   RUN: cycles+1 each cycle. uut_finish=1 -> DONE with status.ok=1.
//    Else cycles==TIMEOUT_CYCLES -> DONE with status.timeout=1.
//    finish and timeout in the same cycle: finish wins.
//   DONE: result_valid=1, index=0 on entry. rd_next advances index by 1.
//    rd_next while index==11 -> IDLE, result_valid=0 the next cycle.
//  Run latency: start edge in cycle T, finish first seen high in cycle T+k -> cycles=k-1.
//  Record (byte index order):
//   0: 8'hA5 magic
//   1-4: n_blocks zero-extended to 32 bits, MSB first
//   5: {cmd18, sclk_speed} zero-padded
//   6: status = {5'b0, overrun, timeout, ok}
//   7-10: cycles, MSB first
//   11: XOR of bytes 0..10
//  rd_byte/rd_last are registered; they update the cycle after DONE entry and the cycle after each rd_next.
//  rd_next in the cycle DONE is entered is ignored. rd_next outside DONE is ignored.
//  uut_finish in IDLE/DONE: ignored. Start edge during RUN: ignored.
//  Start edge during DONE: sets overrun=1 (status bit 2 of the current record). Does not restart.
//  cycles saturates; it never wraps (the timeout is below the max value).
//  rst mid-run or mid-readout: immediate return to reset values; the partial record is discarded.
// CONFIGURATION
//  PERF_MON_FINISH_SYNC_EN defined:
//   uut_finish passes through a 2-FF synchroniser before the FSM (reset 0).
//   Reported cycles is 2 higher for the same run; no compensation.
//  Undefined: uut_finish is sampled directly.
// STRUCTURE
//  perf_mon_pkg:
//   state enum {IDLE,RUN,DONE}
//   REC_LEN=12, REC_MAGIC=8'hA5
//   status bit indices ST_OK=0, ST_TIMEOUT=1, ST_OVERRUN=2
//  Sub-module perf_mon_record_mux:
//   combinational byte select + running XOR checksum from the latched fields and index.
//   Top holds the FSM, counter and output registers.
// TESTING
//  1 Reset: hold rst 3 cycles -> all outputs 0, state IDLE. Pulse uut_finish -> no change.
//  2 Normal run: n_blocks=32'h10, speed=4'h7, cmd18=1; start edge; finish asserted 100 cycles later.
//    Read 12 bytes -> A5 00 00 00 10 17 01 00 00 00 63, checksum OK, rd_last on byte 11.
//  3 Timeout: TIMEOUT_CYCLES=50, finish never asserted -> status=8'h02, cycles=50, result_valid set.
//  4 Edge cases:
//    finish and timeout in the same cycle -> status 8'h01.
//    start edge during DONE -> status 8'h05.
//    uut_start held high after DONE -> no re-arm.
//  5 Reset mid-run (cycle 20) and mid-readout (byte 5) -> outputs return to reset values.
//    The next run measures correctly.
//  6 PERF_MON_FINISH_SYNC_EN: rerun scenario 2 -> cycles=101 (8'h65); all other bytes and the checksum are
//    consistent.

Source files
------------

// File: rtl/perf_mon_pkg.sv
// Shared types and constants for the UUT performance monitor.
// The PERF_MON_FINISH_SYNC_EN build option is handled in uut_perf_monitor.
package perf_mon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int          REC_LEN   = 12;
  localparam logic [7:0]  REC_MAGIC = 8'hA5;
  localparam int          IDX_W     = 4;
  localparam logic [IDX_W-1:0] LAST_IDX = 4'(REC_LEN - 1);

  localparam int ST_OK      = 0;
  localparam int ST_TIMEOUT = 1;
  localparam int ST_OVERRUN = 2;

  // Byte k of a 32-bit word, k=0 being the most significant byte.
  function automatic logic [7:0] msb_byte(input logic [31:0] w, input logic [1:0] k);
    logic [7:0] b;
    case (k)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/perf_mon_record_mux.sv
// Combinational selection of one byte of the 12-byte result record,
// including the running XOR checksum in the final byte.
module perf_mon_record_mux
  import perf_mon_pkg::*;
#(
  parameter int N_BLOCK_SIZE    = 32,
  parameter int SCLK_SPEED_SIZE = 4,
  parameter int CMD18_SIZE      = 1
) (
  input  logic [N_BLOCK_SIZE-1:0]    n_blocks,
  input  logic [SCLK_SPEED_SIZE-1:0] sclk_speed,
  input  logic [CMD18_SIZE-1:0]      cmd18,
  input  logic [7:0]                 status,
  input  logic [31:0]                cycles,
  input  logic [IDX_W-1:0]           index,
  output logic [7:0]                 rec_byte
);

  logic [31:0] nb_ext;
  logic [7:0]  cfg_byte;
  logic [7:0]  body [REC_LEN-1];
  logic [7:0]  csum;

  always_comb begin
    nb_ext = '0;
    nb_ext[N_BLOCK_SIZE-1:0] = n_blocks;
    cfg_byte = '0;
    cfg_byte[SCLK_SPEED_SIZE-1:0] = sclk_speed;
    cfg_byte[SCLK_SPEED_SIZE +: CMD18_SIZE] = cmd18;

    body[0]  = REC_MAGIC;
    body[1]  = msb_byte(nb_ext, 2'd0);
    body[2]  = msb_byte(nb_ext, 2'd1);
    body[3]  = msb_byte(nb_ext, 2'd2);
    body[4]  = msb_byte(nb_ext, 2'd3);
    body[5]  = cfg_byte;
    body[6]  = status;
    body[7]  = msb_byte(cycles, 2'd0);
    body[8]  = msb_byte(cycles, 2'd1);
    body[9]  = msb_byte(cycles, 2'd2);
    body[10] = msb_byte(cycles, 2'd3);

    csum = '0;
    for (int i = 0; i < REC_LEN - 1; i++) begin
      csum = csum ^ body[i];
    end

    // Indices past the record read as zero.
    rec_byte = 8'h00;
    if (index == LAST_IDX) begin
      rec_byte = csum;
    end else if (index < LAST_IDX) begin
      rec_byte = body[index];
    end
  end

endmodule

// File: rtl/uut_perf_monitor.sv
// Times one UUT run (start edge to finish) and serialises a 12-byte result record.
// Build option PERF_MON_FINISH_SYNC_EN adds a 2-FF synchroniser on uut_finish.
//
//  state | meaning
//  IDLE  | waiting for a uut_start rising edge
//  RUN   | counting cycles until uut_finish or timeout
//  DONE  | record available, advanced by rd_next
module uut_perf_monitor
  import perf_mon_pkg::*;
#(
  parameter int          N_BLOCK_SIZE    = 32,
  parameter int          SCLK_SPEED_SIZE = 4,
  parameter int          CMD18_SIZE      = 1,
  parameter logic [31:0] TIMEOUT_CYCLES  = 32'hFFFF_FFFE
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       uut_start,
  input  logic                       uut_finish,
  input  logic [N_BLOCK_SIZE-1:0]    uut_n_blocks,
  input  logic [SCLK_SPEED_SIZE-1:0] uut_sclk_speed,
  input  logic [CMD18_SIZE-1:0]      uut_cmd18,
  output logic                       busy,
  output logic                       result_valid,
  output logic [7:0]                 rd_byte,
  output logic                       rd_last,
  input  logic                       rd_next
);

  state_e                     state_q, state_d;
  logic                       start_q;
  logic [31:0]                cycles_q, cycles_d;
  logic [IDX_W-1:0]           index_q, index_d;
  logic [2:0]                 st_q, st_d;
  logic [N_BLOCK_SIZE-1:0]    n_blocks_q, n_blocks_d;
  logic [SCLK_SPEED_SIZE-1:0] speed_q, speed_d;
  logic [CMD18_SIZE-1:0]      cmd18_q, cmd18_d;
  logic [7:0]                 rd_byte_q, rd_byte_d;
  logic                       rd_last_q, rd_last_d;
  logic                       rd_vld_q, rd_vld_d;

  logic       start_edge;
  logic       finish_s;
  logic       stay_done;
  logic [7:0] mux_byte;

`ifdef PERF_MON_FINISH_SYNC_EN
  logic [1:0] fin_sync_q, fin_sync_d;

  always_comb fin_sync_d = {fin_sync_q[0], uut_finish};

  always_ff @(posedge clk) begin
    if (rst) fin_sync_q <= '0;
    else     fin_sync_q <= fin_sync_d;
  end

  assign finish_s = fin_sync_q[1];
`else
  assign finish_s = uut_finish;
`endif

  assign start_edge = uut_start & ~start_q;

  always_comb begin
    state_d    = state_q;
    cycles_d   = cycles_q;
    index_d    = index_q;
    st_d       = st_q;
    n_blocks_d = n_blocks_q;
    speed_d    = speed_q;
    cmd18_d    = cmd18_q;

    case (state_q)
      IDLE: begin
        if (start_edge) begin
          state_d    = RUN;
          cycles_d   = '0;
          st_d       = '0;
          n_blocks_d = uut_n_blocks;
          speed_d    = uut_sclk_speed;
          cmd18_d    = uut_cmd18;
        end
      end
      RUN: begin
        if (finish_s) begin
          state_d      = DONE;
          index_d      = '0;
          st_d[ST_OK]  = 1'b1;
        end else if (cycles_q == TIMEOUT_CYCLES) begin
          state_d          = DONE;
          index_d          = '0;
          st_d[ST_TIMEOUT] = 1'b1;
        end else if (cycles_q != '1) begin
          cycles_d = cycles_q + 32'd1;
        end
      end
      DONE: begin
        if (start_edge) st_d[ST_OVERRUN] = 1'b1;
        // rd_vld_q is low in the first DONE cycle, so an early rd_next is dropped.
        if (rd_vld_q && rd_next) begin
          if (index_q == LAST_IDX) begin
            state_d = IDLE;
            index_d = '0;
          end else begin
            index_d = index_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  perf_mon_record_mux #(
    .N_BLOCK_SIZE    (N_BLOCK_SIZE),
    .SCLK_SPEED_SIZE (SCLK_SPEED_SIZE),
    .CMD18_SIZE      (CMD18_SIZE)
  ) u_record_mux (
    .n_blocks   (n_blocks_q),
    .sclk_speed (speed_q),
    .cmd18      (cmd18_q),
    .status     ({5'b0, st_q}),
    .cycles     (cycles_q),
    .index      (index_d),
    .rec_byte   (mux_byte)
  );

  // Output registers track index_d so each byte appears the cycle after its rd_next.
  always_comb begin
    stay_done = (state_q == DONE) && (state_d == DONE);
    rd_vld_d  = stay_done;
    rd_byte_d = stay_done ? mux_byte : 8'h00;
    rd_last_d = stay_done && (index_d == LAST_IDX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      start_q    <= 1'b0;
      cycles_q   <= '0;
      index_q    <= '0;
      st_q       <= '0;
      n_blocks_q <= '0;
      speed_q    <= '0;
      cmd18_q    <= '0;
      rd_byte_q  <= 8'h00;
      rd_last_q  <= 1'b0;
      rd_vld_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= uut_start;
      cycles_q   <= cycles_d;
      index_q    <= index_d;
      st_q       <= st_d;
      n_blocks_q <= n_blocks_d;
      speed_q    <= speed_d;
      cmd18_q    <= cmd18_d;
      rd_byte_q  <= rd_byte_d;
      rd_last_q  <= rd_last_d;
      rd_vld_q   <= rd_vld_d;
    end
  end

  assign busy         = (state_q == RUN);
  assign result_valid = rd_vld_q;
  assign rd_byte      = rd_byte_q;
  assign rd_last      = rd_last_q;

endmodule

// File: tb/tb_uut_perf_monitor.sv
// Directed self-checking bench for uut_perf_monitor; a second instance uses a
// 50-cycle timeout for the timeout and finish/timeout-collision cases.
module tb_uut_perf_monitor;

`ifdef PERF_MON_FINISH_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        finish = 1'b0;
  logic [31:0] n_blocks = '0;
  logic [3:0]  speed = '0;
  logic [0:0]  cmd18 = '0;
  logic        start_a = 1'b0, start_t = 1'b0;
  logic        next_a = 1'b0, next_t = 1'b0;
  logic        busy_a, valid_a, last_a, busy_t, valid_t, last_t;
  logic [7:0]  byte_a, byte_t;

  logic        sel = 1'b0;
  logic        o_busy, o_valid, o_last;
  logic [7:0]  o_byte;

  int          n_asserts = 0;
  int          n_fail = 0;
  logic [7:0]  exp_rec [12];
  logic [7:0]  last_obs;

  always #5 clk = ~clk;

  uut_perf_monitor dut_a (
    .clk(clk), .rst(rst), .uut_start(start_a), .uut_finish(finish),
    .uut_n_blocks(n_blocks), .uut_sclk_speed(speed), .uut_cmd18(cmd18),
    .busy(busy_a), .result_valid(valid_a), .rd_byte(byte_a), .rd_last(last_a),
    .rd_next(next_a)
  );

  uut_perf_monitor #(.TIMEOUT_CYCLES(32'd50)) dut_t (
    .clk(clk), .rst(rst), .uut_start(start_t), .uut_finish(finish),
    .uut_n_blocks(n_blocks), .uut_sclk_speed(speed), .uut_cmd18(cmd18),
    .busy(busy_t), .result_valid(valid_t), .rd_byte(byte_t), .rd_last(last_t),
    .rd_next(next_t)
  );

  assign o_busy  = sel ? busy_t  : busy_a;
  assign o_valid = sel ? valid_t : valid_a;
  assign o_byte  = sel ? byte_t  : byte_a;
  assign o_last  = sel ? last_t  : last_a;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel) start_t = v;
    else     start_a = v;
  endtask

  task automatic pulse_next;
    if (sel) next_t = 1'b1;
    else     next_a = 1'b1;
    tick;
    next_t = 1'b0;
    next_a = 1'b0;
  endtask

  task automatic set_rec(input logic [31:0] nb, input logic [7:0] cfg,
                         input logic [7:0] st, input logic [31:0] cyc);
    exp_rec[0]  = 8'hA5;
    exp_rec[1]  = nb[31:24];
    exp_rec[2]  = nb[23:16];
    exp_rec[3]  = nb[15:8];
    exp_rec[4]  = nb[7:0];
    exp_rec[5]  = cfg;
    exp_rec[6]  = st;
    exp_rec[7]  = cyc[31:24];
    exp_rec[8]  = cyc[23:16];
    exp_rec[9]  = cyc[15:8];
    exp_rec[10] = cyc[7:0];
    exp_rec[11] = 8'h00;
    for (int i = 0; i < 11; i++) exp_rec[11] = exp_rec[11] ^ exp_rec[i];
  endtask

  task automatic wait_valid(input string tag, input int bound);
    int n = 0;
    while (o_valid !== 1'b1 && n < bound) begin
      tick;
      n++;
    end
    chk({tag, "_valid"}, {31'b0, o_valid}, 32'd1);
  endtask

  // Start edge, finish raised so it is sampled k cycles after the start edge
  // (k==0: finish never raised). uut_start is left high.
  task automatic do_run(input string tag, input int k);
    set_start(1'b1);
    tick;
    chk({tag, "_busy"}, {31'b0, o_busy}, 32'd1);
    if (k > 0) begin
      repeat (k - 1) tick;
      finish = 1'b1;
    end
    wait_valid(tag, k + 200);
    finish = 1'b0;
  endtask

  task automatic read_record(input string tag, input int nbytes);
    for (int i = 0; i < nbytes; i++) begin
      chk($sformatf("%s_b%0d", tag, i), {24'b0, o_byte}, {24'b0, exp_rec[i]});
      chk($sformatf("%s_last%0d", tag, i), {31'b0, o_last}, {31'b0, (i == 11)});
      last_obs = o_byte;
      pulse_next;
    end
    if (nbytes == 12) chk({tag, "_valid_drop"}, {31'b0, o_valid}, 32'd0);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"},  {31'b0, o_busy},  32'd0);
    chk({tag, "_valid"}, {31'b0, o_valid}, 32'd0);
    chk({tag, "_byte"},  {24'b0, o_byte},  32'd0);
    chk({tag, "_last"},  {31'b0, o_last},  32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 1: reset, then finish while idle
    rst = 1'b1;
    repeat (3) tick;
    sel = 1'b0;
    chk_idle_outputs("rst_a");
    sel = 1'b1;
    chk_idle_outputs("rst_t");
    rst = 1'b0;
    tick;
    finish = 1'b1;
    tick;
    finish = 1'b0;
    repeat (4) tick;
    sel = 1'b0;
    chk_idle_outputs("idle_finish");

    // 2: normal run, finish 100 cycles after the start edge
    n_blocks = 32'h10; speed = 4'h7; cmd18 = 1'b1;
    do_run("s2", 100);
    set_rec(32'h10, 8'h17, 8'h01, 32'(99 + SYNC_LAT));
    read_record("s2", 12);
    chk("s2_csum_hand", {24'b0, last_obs}, (SYNC_LAT == 2) ? 32'hC6 : 32'hC0);
    repeat (3) tick;
    chk("s2_no_rearm_busy", {31'b0, o_busy}, 32'd0);
    set_start(1'b0);
    tick;

    // 3: timeout on the 50-cycle instance
    sel = 1'b1;
    n_blocks = 32'h100; speed = 4'h3; cmd18 = 1'b0;
    do_run("tmo", 0);
    set_rec(32'h100, 8'h03, 8'h02, 32'd50);
    read_record("tmo", 12);
    set_start(1'b0);
    tick;

    // 4a: finish seen in the same cycle the timeout hits
    n_blocks = 32'h1; speed = 4'h1; cmd18 = 1'b1;
    do_run("both", 51 - SYNC_LAT);
    set_rec(32'h1, 8'h11, 8'h01, 32'd50);
    read_record("both", 12);
    set_start(1'b0);
    tick;

    // 4b: start edge during DONE sets overrun; start held high afterwards
    sel = 1'b0;
    n_blocks = 32'hDEADBEEF; speed = 4'hF; cmd18 = 1'b0;
    do_run("ovr", 10);
    set_start(1'b0);
    tick;
    set_start(1'b1);
    tick;
    tick;
    chk("ovr_still_done", {31'b0, o_busy}, 32'd0);
    set_rec(32'hDEADBEEF, 8'h0F, 8'h05, 32'(9 + SYNC_LAT));
    read_record("ovr", 12);
    repeat (5) tick;
    chk("held_no_rearm_busy",  {31'b0, o_busy},  32'd0);
    chk("held_no_rearm_valid", {31'b0, o_valid}, 32'd0);
    set_start(1'b0);
    tick;

    // 5a: reset mid-run at cycle 20
    n_blocks = 32'h22; speed = 4'h5; cmd18 = 1'b1;
    set_start(1'b1);
    repeat (20) tick;
    chk("midrun_busy", {31'b0, o_busy}, 32'd1);
    rst = 1'b1;
    set_start(1'b0);
    tick;
    rst = 1'b0;
    chk_idle_outputs("midrun_rst");
    repeat (3) tick;

    // 5b: reset mid-readout at byte 5
    do_run("mid", 30);
    set_start(1'b0);
    set_rec(32'h22, 8'h15, 8'h01, 32'(29 + SYNC_LAT));
    read_record("mid", 5);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    tick;
    chk_idle_outputs("midread_rst");

    // 5c: next run after reset measures correctly
    n_blocks = 32'h5; speed = 4'h2; cmd18 = 1'b1;
    do_run("post", 40);
    set_rec(32'h5, 8'h12, 8'h01, 32'(39 + SYNC_LAT));
    read_record("post", 12);
    set_start(1'b0);
    repeat (2) tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
